led_matrix_scanner: RTL and testbench

Double-buffered 8x8 RGB frame store and row-scan driver for the LED matrix. Game logic writes pixels into a back buffer at game-clock pace. The scanner reads the front buffer one row at a time and drives the row select (`comm`) and the active-low colour columns (`LedR`/`LedG`/`LedB`). A frame-boundary swap handshake lets the game publish a finished frame without tearing. It replaces the ad-hoc combinational map-to-LED path and sits between the game FSM and the matrix pins.

---
 rtl/led_matrix_pkg.sv | 38 +++
 rtl/row_tick_gen.sv | 30 +++
 rtl/led_matrix_scanner.sv | 113 +++++++++++
 tb/tb_led_matrix_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared constants and types for the LED matrix scanner.
//   ROWS/COLS   : matrix geometry
//   C_R/C_G/C_B : bit positions of the colour channels inside a pixel
//   LED_OFF     : column value with every (active-low) LED dark
//   row_to_led  : converts one stored row into active-low column vectors
package led_matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  localparam int C_R = 2;
  localparam int C_G = 1;
  localparam int C_B = 0;

  localparam logic [7:0] LED_OFF = 8'hFF;

  typedef logic [2:0]          rgb_t;
  typedef rgb_t [COLS-1:0]     row_t;
  typedef row_t [ROWS-1:0]     bank_t;

  // Column vectors use [0:7] so that bit y is pixel column y.
  typedef struct packed {
    logic [0:7] r;
    logic [0:7] g;
    logic [0:7] b;
  } led_row_t;

  function automatic led_row_t row_to_led(input row_t row);
    led_row_t l;
    for (int y = 0; y < COLS; y++) begin
      l.r[y] = ~row[y][C_R];
      l.g[y] = ~row[y][C_G];
      l.b[y] = ~row[y][C_B];
    end
    return l;
  endfunction

endpackage

// File: rtl/row_tick_gen.sv
// row_tick_gen: free-running divider producing a one-cycle tick every
// ROW_DIV clocks. Shared with the 7-segment digit scanner.
//   SYS_CLK : clock
//   RST     : synchronous active-high reset (counter to 0)
//   tick    : high while the counter sits at its terminal count ROW_DIV-1
module row_tick_gen #(
  parameter int ROW_DIV = 50000
) (
  input  logic SYS_CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(ROW_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 RGB frame store and row-scan driver.
//   SYS_CLK, RST            : clock, synchronous active-high reset
//   wr_en/wr_x/wr_y/wr_rgb  : single-pixel write into the back bank
//   clr                     : zero the whole back bank (a same-cycle write wins)
//   swap_req                : request front/back exchange at the next 7->0 row tick
//   blank                   : force LEDs dark and drop enable (1-cycle latency)
//   swap_ack, frame_start   : one-cycle pulses aligned with comm returning to 0
//   comm                    : active row index
//   enable                  : registered ~blank
//   LedR/LedG/LedB [0:7]    : active-low column data for row comm
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROW_DIV = 50000
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clr,
  input  logic       swap_req,
  input  logic       blank,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [2:0] comm,
  output logic       enable,
  output logic [0:7] LedR,
  output logic [0:7] LedG,
  output logic [0:7] LedB
);

  logic tick;

  row_tick_gen #(.ROW_DIV(ROW_DIV)) u_tick (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .tick    (tick)
  );

  // Frame store: flops so clr is single-cycle and a whole row reads at once.
  bank_t [1:0] bank_q;

  logic       front_sel_q, front_sel_d;
  logic       pending_q, pending_d;
  logic [2:0] comm_q, comm_d;
  logic       load_q;       // cycle after a row tick (or after reset): fetch row
  row_t       row_q, row_d; // row latched at load time; later bank edits wait
  led_row_t   led_q, led_d;
  logic       swap_ack_q, frame_start_q, enable_q;

  logic wrap, swap_now, back_sel;

  assign back_sel = ~front_sel_q;
  assign wrap     = tick && (comm_q == 3'd7);
  // A request arriving on the wrap tick itself is honoured immediately.
  assign swap_now = wrap && (pending_q || swap_req);

  // Writes use the pre-swap back bank, so a write on the swap cycle
  // lands in the bank that is about to become visible.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      bank_q <= '0;
    end else begin
      if (clr)   bank_q[back_sel]             <= '0;
      if (wr_en) bank_q[back_sel][wr_x][wr_y] <= wr_rgb;
    end
  end

  always_comb begin
    comm_d      = tick ? comm_q + 3'd1 : comm_q;
    front_sel_d = front_sel_q ^ swap_now;
    pending_d   = swap_now ? 1'b0 : (pending_q | swap_req);
    row_d       = load_q ? bank_q[front_sel_q][comm_q] : row_q;
    // Row tick gives a one-cycle ghost gap; blank overrides everything after.
    if (tick || blank) led_d = '{r: LED_OFF, g: LED_OFF, b: LED_OFF};
    else               led_d = row_to_led(row_d);
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      comm_q        <= '0;
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      load_q        <= 1'b1;
      row_q         <= '0;
      led_q         <= '{r: LED_OFF, g: LED_OFF, b: LED_OFF};
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      enable_q      <= 1'b1;
    end else begin
      comm_q        <= comm_d;
      front_sel_q   <= front_sel_d;
      pending_q     <= pending_d;
      load_q        <= tick;
      row_q         <= row_d;
      led_q         <= led_d;
      swap_ack_q    <= swap_now;
      frame_start_q <= wrap;
      enable_q      <= ~blank;
    end
  end

  assign comm        = comm_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign enable      = enable_q;
  assign LedR        = led_q.r;
  assign LedG        = led_q.g;
  assign LedB        = led_q.b;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

  localparam int RD = 4;

  logic       SYS_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0, clr = 1'b0, swap_req = 1'b0, blank = 1'b0;
  logic [2:0] wr_x = '0, wr_y = '0, wr_rgb = '0;
  logic       swap_ack, frame_start, enable;
  logic [2:0] comm;
  logic [0:7] LedR, LedG, LedB;

  led_matrix_scanner #(.ROW_DIV(RD)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .clr(clr), .swap_req(swap_req), .blank(blank),
    .swap_ack(swap_ack), .frame_start(frame_start), .comm(comm),
    .enable(enable), .LedR(LedR), .LedG(LedG), .LedB(LedB)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int tests = 0, fails = 0;
  int k = 0;  // rising edges since reset release

  typedef struct { logic [2:0] x, y, rgb; logic [0:7] r, g, b; } vec_t;
  typedef struct { logic [2:0] row; logic [0:7] r, g, b; } rowexp_t;

  vec_t    tbl[8];
  rowexp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (k=%0d): got %0h want %0h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    #1;
    k++;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " comm"}, 32'(comm), 0);
    chk({nm, " leds"}, 32'({LedR, LedG, LedB}), 32'hFFFFFF);
    chk({nm, " enable"}, 32'(enable), 1);
    chk({nm, " swap_ack"}, 32'(swap_ack), 0);
    chk({nm, " frame_start"}, 32'(frame_start), 0);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (swap_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pops one expected row per data phase (first cycle after each ghost gap).
  task automatic check_frame(input string nm);
    for (int i = 0; i < 32; i++) begin
      step();
      if (k % 4 == 1) begin
        rowexp_t e;
        if (sb.size() == 0) begin
          chk({nm, " scoreboard underrun"}, 0, 1);
        end else begin
          e = sb.pop_front();
          chk({nm, " row"}, 32'(comm), 32'(e.row));
          chk({nm, " LedR"}, 32'(LedR), 32'(e.r));
          chk({nm, " LedG"}, 32'(LedG), 32'(e.g));
          chk({nm, " LedB"}, 32'(LedB), 32'(e.b));
        end
      end
    end
    chk({nm, " scoreboard drained"}, 32'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          acks, ack_k, fsn, fs_k, bad;
    logic [23:0] led_after;

    // One pixel per row; expected columns are active-low with index y = bit y of [0:7].
    tbl[0] = '{3'd0, 3'd6, 3'b001, 8'hFF,       8'hFF,       8'b11111101};
    tbl[1] = '{3'd1, 3'd3, 3'b110, 8'b11101111, 8'b11101111, 8'hFF};
    tbl[2] = '{3'd2, 3'd5, 3'b100, 8'b11111011, 8'hFF,       8'hFF};
    tbl[3] = '{3'd3, 3'd0, 3'b111, 8'b01111111, 8'b01111111, 8'b01111111};
    tbl[4] = '{3'd4, 3'd7, 3'b010, 8'hFF,       8'b11111110, 8'hFF};
    tbl[5] = '{3'd5, 3'd2, 3'b000, 8'hFF,       8'hFF,       8'hFF};
    tbl[6] = '{3'd6, 3'd1, 3'b101, 8'b10111111, 8'hFF,       8'b10111111};
    tbl[7] = '{3'd7, 3'd4, 3'b011, 8'hFF,       8'b11110111, 8'b11110111};

    // Reset
    RST = 1'b1;
    step(); step();
    chk_reset_state("reset");
    RST = 1'b0;
    k = 0;

    // Idle scan: comm steps every RD cycles, LEDs dark, frame_start every 32
    for (int i = 0; i < 64; i++) begin
      step();
      chk("idle comm", 32'(comm), 32'((k / 4) % 8));
      chk("idle leds", 32'({LedR, LedG, LedB}), 32'hFFFFFF);
      chk("idle frame_start", 32'(frame_start), 32'(k % 32 == 0));
    end

    // Table writes into back bank, then swap and scan the frame
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_x = tbl[i].x; wr_y = tbl[i].y; wr_rgb = tbl[i].rgb;
      sb.push_back('{tbl[i].x, tbl[i].r, tbl[i].g, tbl[i].b});
      step();
    end
    wr_en = 1'b0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    wait_ack(ok);
    chk("B swap_ack seen", 32'(ok), 1);
    chk("B swap_ack at 7->0", 32'(k % 32), 0);
    chk("B frame_start with ack", 32'(frame_start), 1);
    check_frame("B");

    // Two requests in one frame merge into a single swap
    step(); step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (8) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    acks = 0; ack_k = -1; led_after = '0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (swap_ack) begin acks++; ack_k = k; end
      if (ack_k >= 0 && k == ack_k + 1) led_after = {LedR, LedG, LedB};
    end
    chk("C single ack", 32'(acks), 1);
    chk("C ack at boundary", 32'(ack_k % 32), 0);
    chk("C stale back bank shown dark", 32'(led_after), 32'hFFFFFF);

    // Request + write in the swap cycle itself: 1-cycle latency, pixel visible
    for (int i = 0; i < 32 && (k % 32) != 31; i++) step();
    chk("D align", 32'(k % 32), 31);
    swap_req = 1'b1; wr_en = 1'b1; wr_x = 3'd0; wr_y = 3'd0; wr_rgb = 3'b010;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    chk("D swap_ack", 32'(swap_ack), 1);
    chk("D frame_start", 32'(frame_start), 1);
    chk("D gap leds", 32'({LedR, LedG, LedB}), 32'hFFFFFF);
    step();
    chk("D swap_ack one-shot", 32'(swap_ack), 0);
    chk("D comm", 32'(comm), 0);
    chk("D LedR", 32'(LedR), 32'hFF);
    chk("D LedG", 32'(LedG), 32'b01111111);
    chk("D LedB", 32'(LedB), 32'b11111101);

    // clr with a same-cycle write: only the written pixel survives
    wr_en = 1'b1; wr_x = 3'd2; wr_y = 3'd2; wr_rgb = 3'b111; step();
    clr = 1'b1; wr_x = 3'd3; wr_y = 3'd3; wr_rgb = 3'b101; step();
    clr = 1'b0; wr_en = 1'b0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (r == 3) sb.push_back('{3'd3, 8'b11101111, 8'hFF, 8'b11101111});
      else        sb.push_back('{3'(r), 8'hFF, 8'hFF, 8'hFF});
    end
    wait_ack(ok);
    chk("E swap_ack seen", 32'(ok), 1);
    check_frame("E");

    // blank during row 3
    for (int i = 0; i < 32 && (k % 32) != 13; i++) step();
    chk("F pre comm", 32'(comm), 3);
    chk("F pre LedR", 32'(LedR), 32'b11101111);
    chk("F pre enable", 32'(enable), 1);
    blank = 1'b1; step();
    chk("F blank leds", 32'({LedR, LedG, LedB}), 32'hFFFFFF);
    chk("F blank enable", 32'(enable), 0);
    blank = 1'b0; step();
    chk("F restore LedR", 32'(LedR), 32'b11101111);
    chk("F restore LedB", 32'(LedB), 32'b11101111);
    chk("F restore enable", 32'(enable), 1);

    // Reset with a pending swap at comm=6: pending is lost
    for (int i = 0; i < 32 && (k % 32) != 24; i++) step();
    chk("G comm", 32'(comm), 6);
    swap_req = 1'b1; step(); swap_req = 1'b0;
    step();
    RST = 1'b1; step();
    chk_reset_state("G reset");
    RST = 1'b0;
    k = 0;
    acks = 0; fsn = 0; fs_k = -1; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (swap_ack) acks++;
      if (frame_start) begin fsn++; fs_k = k; end
      if ({LedR, LedG, LedB} !== 24'hFFFFFF) bad++;
    end
    chk("G no swap_ack", 32'(acks), 0);
    chk("G frame_start count", 32'(fsn), 1);
    chk("G frame_start time", 32'(fs_k), 32);
    chk("G banks cleared", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
